// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared definitions for the sprite display path: the transparent colour key,
// command word field positions, action / action_type codes, and a small
// helper used to decide whether a layer contributes to a pixel.
// No ports (package).
package sprite_pkg;

    // Colour a sprite block outputs when it has nothing to draw.
    localparam logic [23:0] SPRITE_TRANSPARENT = 24'h202020;

    // Command word layout (32 bits).
    localparam int CMD_COMP_HI = 31;
    localparam int CMD_COMP_LO = 26;
    localparam int CMD_ACT_HI  = 20;
    localparam int CMD_ACT_LO  = 17;
    localparam int CMD_TYPE_HI = 16;
    localparam int CMD_TYPE_LO = 14;
    localparam int CMD_DATA_HI = 12;
    localparam int CMD_DATA_LO = 0;

    typedef enum logic [3:0] {
        ACT_UPDATE = 4'h1,
        ACT_COMMIT = 4'hF
    } action_e;

    typedef enum logic [2:0] {
        SET_EN    = 3'b001,
        SET_BG_HI = 3'b011,
        SET_BG_LO = 3'b100
    } action_type_e;

    // A layer draws when it is enabled and not showing the colour key.
    function automatic logic is_opaque(input logic        en,
                                       input logic [23:0] rgb,
                                       input logic [23:0] key);
        return en && (rgb != key);
    endfunction

endpackage

// File: rtl/layer_priority_sel.sv
// layer_priority_sel
// Combinational fixed-priority select: returns the colour of the
// lowest-index opaque layer, or the background colour when none is opaque.
// Ports:
//   layer_rgb  in  24*NUM_LAYERS  layer i colour in bits [24i+23:24i]
//   opaque     in  NUM_LAYERS     per-layer opaque flags
//   bg_rgb     in  24             background colour
//   rgb        out 24             selected colour
module layer_priority_sel #(
    parameter int NUM_LAYERS = 8
) (
    input  logic [24*NUM_LAYERS-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]    opaque,
    input  logic [23:0]              bg_rgb,
    output logic [23:0]              rgb
);

    // Walk from the highest index down so the lowest opaque index is the
    // last assignment and therefore wins.
    always_comb begin
        rgb = bg_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                rgb = layer_rgb[24*i +: 24];
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor
// Composites up to NUM_LAYERS sprite layer colours with fixed priority
// (layer 0 on top), fills uncovered pixels with a programmable background,
// and registers the result for the VGA output. Layer enables and background
// colour are written into shadow registers via the command bus and copied to
// the active set only at frame start (hcount==0 && vcount==0).
//
// Optional feature macro: SPRITE_COMPOSITOR_COLLISION_EN
//   defined   -> per-frame layer-0 collision flags on collision_mask
//   undefined -> collision_mask tied to 0
//
// Ports:
//   clk             in  1             pixel clock
//   reset           in  1             synchronous, active-high reset
//   write           in  1             writedata valid
//   writedata       in  32            command word
//   hcount          in  10            current pixel column
//   vcount          in  10            current pixel row
//   layer_rgb       in  24*NUM_LAYERS layer colours, layer i in [24i+23:24i]
//   rgb_out         out 24            composited pixel (2-cycle latency)
//   hcount_out      out 10            hcount aligned with rgb_out
//   vcount_out      out 10            vcount aligned with rgb_out
//   collision_mask  out NUM_LAYERS    previous-frame collision flags
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int          NUM_LAYERS   = 8,
    parameter logic [5:0]  COMPONENT_ID = 6'b000001,
    parameter logic [23:0] TRANSPARENT  = SPRITE_TRANSPARENT,
    parameter logic [23:0] BG_DEFAULT   = 24'h5C94FC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [31:0]              writedata,
    input  logic [9:0]               hcount,
    input  logic [9:0]               vcount,
    input  logic [24*NUM_LAYERS-1:0] layer_rgb,
    output logic [23:0]              rgb_out,
    output logic [9:0]               hcount_out,
    output logic [9:0]               vcount_out,
    output logic [NUM_LAYERS-1:0]    collision_mask
);

    // ---------------- command decode ----------------
    logic [5:0]  cmd_comp;
    logic [3:0]  cmd_action;
    logic [2:0]  cmd_type;
    logic [12:0] cmd_data;
    logic        cmd_hit;
    logic        cmd_update;
    logic        cmd_commit;
    logic        unused_cmd_bits;

    assign cmd_comp   = writedata[CMD_COMP_HI:CMD_COMP_LO];
    assign cmd_action = writedata[CMD_ACT_HI:CMD_ACT_LO];
    assign cmd_type   = writedata[CMD_TYPE_HI:CMD_TYPE_LO];
    assign cmd_data   = writedata[CMD_DATA_HI:CMD_DATA_LO];

    assign unused_cmd_bits = ^{writedata[25:21], writedata[13], cmd_data[12]};

    assign cmd_hit    = write && (cmd_comp == COMPONENT_ID);
    assign cmd_update = cmd_hit && (cmd_action == ACT_UPDATE);
    assign cmd_commit = cmd_hit && (cmd_action == ACT_COMMIT);

    logic frame_start;
    assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);

    // ---------------- shadow / active settings ----------------
    logic [NUM_LAYERS-1:0] shadow_en;
    logic [NUM_LAYERS-1:0] active_en;
    logic [23:0]           shadow_bg;
    logic [23:0]           active_bg;
    logic                  commit_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_en      <= '1;
            active_en      <= '1;
            shadow_bg      <= BG_DEFAULT;
            active_bg      <= BG_DEFAULT;
            commit_pending <= 1'b0;
        end else begin
            if (cmd_update) begin
                case (cmd_type)
                    SET_EN:    shadow_en        <= cmd_data[NUM_LAYERS-1:0];
                    SET_BG_HI: shadow_bg[23:12] <= cmd_data[11:0];
                    SET_BG_LO: shadow_bg[11:0]  <= cmd_data[11:0];
                    default:   ;
                endcase
            end

            // The active copy takes the shadow value held before any write in
            // this same cycle. A commit arriving on the frame-start cycle is
            // parked for the next frame rather than applied now.
            if (frame_start) begin
                if (commit_pending) begin
                    active_en <= shadow_en;
                    active_bg <= shadow_bg;
                end
                commit_pending <= cmd_commit;
            end else if (cmd_commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // ---------------- opaque evaluation ----------------
    logic [NUM_LAYERS-1:0] opaque;

    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            opaque[i] = is_opaque(active_en[i], layer_rgb[24*i +: 24], TRANSPARENT);
        end
    end

    // ---------------- S1 ----------------
    logic [24*NUM_LAYERS-1:0] s1_rgb;
    logic [NUM_LAYERS-1:0]    s1_opaque;
    logic [9:0]               s1_hcount;
    logic [9:0]               s1_vcount;
    logic [23:0]              s1_bg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_rgb    <= '0;
            s1_opaque <= '0;
            s1_hcount <= '0;
            s1_vcount <= '0;
            s1_bg     <= '0;
        end else begin
            s1_rgb    <= layer_rgb;
            s1_opaque <= opaque;
            s1_hcount <= hcount;
            s1_vcount <= vcount;
            s1_bg     <= active_bg;
        end
    end

    // ---------------- S2 ----------------
    logic [23:0] sel_rgb;

    layer_priority_sel #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_sel (
        .layer_rgb (s1_rgb),
        .opaque    (s1_opaque),
        .bg_rgb    (s1_bg),
        .rgb       (sel_rgb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out    <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            rgb_out    <= sel_rgb;
            hcount_out <= s1_hcount;
            vcount_out <= s1_vcount;
        end
    end

    // ---------------- collision tracking ----------------
`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    logic [NUM_LAYERS-1:0] coll_hits;
    logic [NUM_LAYERS-1:0] coll_work;
    logic [NUM_LAYERS-1:0] coll_mask_q;

    // Bit 0 never set: layer 0 cannot collide with itself.
    always_comb begin
        coll_hits = '0;
        for (int j = 1; j < NUM_LAYERS; j++) begin
            coll_hits[j] = opaque[0] && opaque[j];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coll_work   <= '0;
            coll_mask_q <= '0;
        end else if (frame_start) begin
            coll_mask_q <= coll_work;
            coll_work   <= '0;
        end else begin
            coll_work <= coll_work | coll_hits;
        end
    end

    assign collision_mask = coll_mask_q;
`else
    assign collision_mask = '0;
`endif

endmodule
